inst_queue: RTL and testbench
=============================

# inst_queue

Instruction queue between the fetch-side branch select/check stage and decode. Accepts a compressed group of 0–4 contiguous instructions per cycle with their branch-prediction metadata and fetch-exception info. Stores them in a circular buffer and presents up to 2 head entries per cycle to decode. A backend flush empties the queue in one cycle.

## Interface
Parameters:
- `DEPTH`, 16 — entry count; power of two, ≥ 8.
- `CKPT_W`, `ALL_CHECKPOINT_LEN` — width of one branch checkpoint.

Ports:
- `clk` — in, 1 — clock. One clock; all state updates on its rising edge.
- `rst` — in, 1 — reset. Synchronous, active-high.
- `flush_i` — in, 1 — backend flush: branch mis-repair, exception or eret.
- `IF_valid_i` — in, 1 — write group valid.
- `IF_instNum_i` — in, 3 — number of instructions in the group, 0..4.
- `IF_inst_p_i` — in, 128 — compressed instructions; slot k occupies bits [32k+31:32k].
- `IF_predDest_p_i` — in, 128 — predicted target per slot.
- `IF_predTake_p_i` — in, 4 — predicted taken per slot.
- `IF_predInfo_p_i` — in, 4*CKPT_W — checkpoint per slot.
- `IF_instBasePC_i` — in, 32 — PC of slot 0.
- `IF_hasException_i`, `IF_isRefill_i` — in, 1 each — group fetch exception.
- `IF_ExcCode_i` — in, 5 — group exception code.
- `IQ_allowin_o` — out, 1 — queue can take a full 4-instruction group.
- `IQ_valid_o` — out, 2 — head entries valid. bit1 implies bit0.
- `IQ_inst_o`, `IQ_PC_o`, `IQ_predDest_o` — out, 64 each — head0 in [31:0], head1 in [63:32].
- `IQ_predTake_o` — out, 2 — predicted taken for head0/head1.
- `IQ_predInfo_o` — out, 2*CKPT_W — checkpoint for head0/head1.
- `IQ_hasException_o`, `IQ_isRefill_o` — out, 2 each — exception flags for head0/head1.
- `IQ_ExcCode_o` — out, 10 — exception code, 5 bits per head entry.
- `ID_readNum_i` — in, 2 — entries decode consumes this cycle. 3 is treated as 2.
- `IQ_count_o` — out, log2(DEPTH)+1 — occupied entries.

## Operation
- **State:** entry RAM[DEPTH] and `head`/`tail` pointers, each log2(DEPTH) bits and wrapping modulo DEPTH. `count` is log2(DEPTH)+1 bits and registered.
- **Entry contents:** inst, PC, predDest, predTake, checkpoint, hasException, isRefill, ExcCode.
- **Allow-in:** `IQ_allowin_o = (DEPTH − count) ≥ 4`. It is computed from the registered count only and never depends on same-cycle reads.
- **Write enable:** `wr = IF_valid_i & IQ_allowin_o & !flush_i & (IF_instNum_i != 0)`.
- **Write:** slot k (k < IF_instNum_i) is written to RAM[tail+k] with:
  - PC = IF_instBasePC_i + 4k, 32-bit wrap;
  - the group exception fields copied into every written slot.
  - Then `tail += IF_instNum_i`.
- **Rejected write:** if IF_valid_i is high while allowin is low, nothing is written. The upstream stage holds its group.
- **Head outputs:**
  - `IQ_valid_o[0] = count ≥ 1`; `IQ_valid_o[1] = count ≥ 2`.
  - Head0 = RAM[head], head1 = RAM[head+1].
  - Data fields of invalid heads are don't-care; the bench checks only valid heads.
- **Read:** `rd = min(ID_readNum_i clamped to 2, count)`, forced to 0 on flush. Then `head += rd`.
- **Count update:** `count_next = count + (wr ? IF_instNum_i : 0) − rd`.
- **Flush:** next cycle head = tail = 0 and count = 0. A flush overrides a same-cycle write and read. RAM contents are not cleared.
- **Reset:** identical to flush.

## Timing
- **Reset outputs:** count 0, IQ_valid_o 00, IQ_allowin_o 1.
- **Write-to-head latency:** 1 cycle. There is no bypass, so an entry written in cycle N is visible at head from cycle N+1.
- **Read-to-next-head latency:** 1 cycle. Consumed entries leave the head at the next edge.
- **Simultaneous write and read** in one cycle are independent. Example: count = DEPTH−4, write 4 and read 2 → DEPTH−2 next cycle.
- **Wrap-around:** a group crossing index DEPTH−1 splits across the end and start of RAM with order preserved.
- **Full:** count = DEPTH can only be reached by writes at count ≤ DEPTH−4; count never exceeds DEPTH.
- **Empty:** reads are ignored.

## Test plan
- **Reset:** assert rst 2 cycles → IQ_allowin_o=1, IQ_valid_o=00, IQ_count_o=0.
- **Write then read:**
  - Write num=3, base 0xBFC00000, insts A/B/C → next cycle valid=11, PC0=0xBFC00000, PC1=0xBFC00004, count=3.
  - readNum=2 → next cycle head0=C, PC0=0xBFC00008, valid=01.
- **Fill and allow-in:**
  - With DEPTH=16, four 4-instruction writes and no reads → count=16, allowin=0.
  - A fifth IF_valid_i is not written.
  - readNum=2 → count=14, allowin still 0.
  - readNum=2 again → count=12, allowin=1.
- **Wrap:** tail=14, write 4 → entries land at RAM 14,15,0,1; four successive reads return them in order with consecutive PCs.
- **Flush priority:** count=6, same cycle write num=4, readNum=2, flush_i=1 → next cycle count=0, valid=00, allowin=1.
- **Exception and over-read:**
  - Write num=1 with hasException=1, ExcCode=0x04, isRefill=1 → head0 carries those flags.
  - readNum=3 at count=1 → only 1 popped; count=0.

Source files
------------

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: accepts up to four instructions
// per cycle into a circular buffer and presents up to two head entries.
`ifndef ALL_CHECKPOINT_LEN
`define ALL_CHECKPOINT_LEN 8
`endif

module inst_queue #(
    parameter int DEPTH  = 16,
    parameter int CKPT_W = `ALL_CHECKPOINT_LEN
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_i,
    input  logic                          IF_valid_i,
    input  logic [2:0]                    IF_instNum_i,
    input  logic [127:0]                  IF_inst_p_i,
    input  logic [127:0]                  IF_predDest_p_i,
    input  logic [3:0]                    IF_predTake_p_i,
    input  logic [4*CKPT_W-1:0]           IF_predInfo_p_i,
    input  logic [31:0]                   IF_instBasePC_i,
    input  logic                          IF_hasException_i,
    input  logic                          IF_isRefill_i,
    input  logic [4:0]                    IF_ExcCode_i,
    output logic                          IQ_allowin_o,
    output logic [1:0]                    IQ_valid_o,
    output logic [63:0]                   IQ_inst_o,
    output logic [63:0]                   IQ_PC_o,
    output logic [63:0]                   IQ_predDest_o,
    output logic [1:0]                    IQ_predTake_o,
    output logic [2*CKPT_W-1:0]           IQ_predInfo_o,
    output logic [1:0]                    IQ_hasException_o,
    output logic [1:0]                    IQ_isRefill_o,
    output logic [9:0]                    IQ_ExcCode_o,
    input  logic [1:0]                    ID_readNum_i,
    output logic [$clog2(DEPTH):0]        IQ_count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]       inst_mem_r [DEPTH];
    logic [31:0]       pc_mem_r   [DEPTH];
    logic [31:0]       dest_mem_r [DEPTH];
    logic              take_mem_r [DEPTH];
    logic [CKPT_W-1:0] ckpt_mem_r [DEPTH];
    logic              exc_mem_r  [DEPTH];
    logic              refill_mem_r [DEPTH];
    logic [4:0]        code_mem_r [DEPTH];

    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [CW-1:0] count_r;

    logic          allowin_s;
    logic          wr_s;
    logic [2:0]    wr_num_s;
    logic [1:0]    rd_req_s;
    logic [1:0]    rd_s;
    logic [CW-1:0] count_next_s;
    logic [AW-1:0] head1_s;
    logic [3:0]    wr_en_s;
    logic [AW-1:0] wr_idx_s [4];
    logic [31:0]   wr_pc_s  [4];

    // Allow-in looks only at the registered count so it never depends on decode.
    assign allowin_s = (count_r <= CW'(DEPTH - 4));
    assign wr_s      = IF_valid_i & allowin_s & ~flush_i & (IF_instNum_i != 3'd0);
    assign wr_num_s  = wr_s ? IF_instNum_i : 3'd0;

    // Read amount: clamp request to two, then to the occupancy; flush cancels it.
    always_comb begin
        rd_req_s = ID_readNum_i[1] ? 2'd2 : ID_readNum_i;
        if (flush_i) begin
            rd_s = 2'd0;
        end else if (CW'(rd_req_s) > count_r) begin
            rd_s = count_r[1:0];
        end else begin
            rd_s = rd_req_s;
        end
    end

    assign count_next_s = count_r + CW'(wr_num_s) - CW'(rd_s);

    // Per-slot write enables, target indices (wrapping) and PCs.
    always_comb begin
        wr_en_s = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            wr_en_s[k]  = wr_s && (3'(k) < IF_instNum_i);
            wr_idx_s[k] = tail_r + AW'(k);
            wr_pc_s[k]  = IF_instBasePC_i + 32'(k * 4);
        end
    end

    // Entry storage; deliberately not cleared by reset or flush.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_en_s[k]) begin
                inst_mem_r[wr_idx_s[k]]   <= IF_inst_p_i[32*k +: 32];
                pc_mem_r[wr_idx_s[k]]     <= wr_pc_s[k];
                dest_mem_r[wr_idx_s[k]]   <= IF_predDest_p_i[32*k +: 32];
                take_mem_r[wr_idx_s[k]]   <= IF_predTake_p_i[k];
                ckpt_mem_r[wr_idx_s[k]]   <= IF_predInfo_p_i[CKPT_W*k +: CKPT_W];
                exc_mem_r[wr_idx_s[k]]    <= IF_hasException_i;
                refill_mem_r[wr_idx_s[k]] <= IF_isRefill_i;
                code_mem_r[wr_idx_s[k]]   <= IF_ExcCode_i;
            end
        end
    end

    // Pointers and occupancy; flush wins over any same-cycle write or read.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            head_r  <= head_r + AW'(rd_s);
            tail_r  <= tail_r + AW'(wr_num_s);
            count_r <= count_next_s;
        end
    end

    assign head1_s = head_r + AW'(1);

    assign IQ_allowin_o      = allowin_s;
    assign IQ_count_o        = count_r;
    assign IQ_valid_o        = {(count_r >= CW'(2)), (count_r >= CW'(1))};
    assign IQ_inst_o         = {inst_mem_r[head1_s], inst_mem_r[head_r]};
    assign IQ_PC_o           = {pc_mem_r[head1_s], pc_mem_r[head_r]};
    assign IQ_predDest_o     = {dest_mem_r[head1_s], dest_mem_r[head_r]};
    assign IQ_predTake_o     = {take_mem_r[head1_s], take_mem_r[head_r]};
    assign IQ_predInfo_o     = {ckpt_mem_r[head1_s], ckpt_mem_r[head_r]};
    assign IQ_hasException_o = {exc_mem_r[head1_s], exc_mem_r[head_r]};
    assign IQ_isRefill_o     = {refill_mem_r[head1_s], refill_mem_r[head_r]};
    assign IQ_ExcCode_o      = {code_mem_r[head1_s], code_mem_r[head_r]};

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: a queue-based reference model predicts the
// head entries, occupancy and allow-in; a negedge monitor compares them.
module tb_inst_queue;

    localparam int DEPTH  = 16;
    localparam int CKPT_W = 8;

    typedef struct {
        logic [31:0]       inst;
        logic [31:0]       pc;
        logic [31:0]       dest;
        logic              take;
        logic [CKPT_W-1:0] ckpt;
        logic              exc;
        logic              refill;
        logic [4:0]        code;
    } ent_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush_i;
    logic                 IF_valid_i;
    logic [2:0]           IF_instNum_i;
    logic [127:0]         IF_inst_p_i;
    logic [127:0]         IF_predDest_p_i;
    logic [3:0]           IF_predTake_p_i;
    logic [4*CKPT_W-1:0]  IF_predInfo_p_i;
    logic [31:0]          IF_instBasePC_i;
    logic                 IF_hasException_i;
    logic                 IF_isRefill_i;
    logic [4:0]           IF_ExcCode_i;
    logic                 IQ_allowin_o;
    logic [1:0]           IQ_valid_o;
    logic [63:0]          IQ_inst_o;
    logic [63:0]          IQ_PC_o;
    logic [63:0]          IQ_predDest_o;
    logic [1:0]           IQ_predTake_o;
    logic [2*CKPT_W-1:0]  IQ_predInfo_o;
    logic [1:0]           IQ_hasException_o;
    logic [1:0]           IQ_isRefill_o;
    logic [9:0]           IQ_ExcCode_o;
    logic [1:0]           ID_readNum_i;
    logic [4:0]           IQ_count_o;

    inst_queue #(.DEPTH(DEPTH), .CKPT_W(CKPT_W)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .IF_valid_i(IF_valid_i), .IF_instNum_i(IF_instNum_i),
        .IF_inst_p_i(IF_inst_p_i), .IF_predDest_p_i(IF_predDest_p_i),
        .IF_predTake_p_i(IF_predTake_p_i), .IF_predInfo_p_i(IF_predInfo_p_i),
        .IF_instBasePC_i(IF_instBasePC_i), .IF_hasException_i(IF_hasException_i),
        .IF_isRefill_i(IF_isRefill_i), .IF_ExcCode_i(IF_ExcCode_i),
        .IQ_allowin_o(IQ_allowin_o), .IQ_valid_o(IQ_valid_o),
        .IQ_inst_o(IQ_inst_o), .IQ_PC_o(IQ_PC_o), .IQ_predDest_o(IQ_predDest_o),
        .IQ_predTake_o(IQ_predTake_o), .IQ_predInfo_o(IQ_predInfo_o),
        .IQ_hasException_o(IQ_hasException_o), .IQ_isRefill_o(IQ_isRefill_o),
        .IQ_ExcCode_o(IQ_ExcCode_o), .ID_readNum_i(ID_readNum_i),
        .IQ_count_o(IQ_count_o)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;
    ent_t exp_q[$];
    logic [127:0] last_inst;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the queue is simply a list of entries in program order.
    task automatic model_step();
        int rd;
        bit acc;
        ent_t e;
        if (rst || flush_i) begin
            exp_q.delete();
        end else begin
            acc = IF_valid_i && ((DEPTH - exp_q.size()) >= 4) && (IF_instNum_i != 3'd0);
            rd  = (int'(ID_readNum_i) > 2) ? 2 : int'(ID_readNum_i);
            if (rd > exp_q.size()) rd = exp_q.size();
            repeat (rd) void'(exp_q.pop_front());
            if (acc) begin
                for (int k = 0; k < int'(IF_instNum_i); k++) begin
                    e.inst   = IF_inst_p_i[32*k +: 32];
                    e.pc     = IF_instBasePC_i + 32'(4 * k);
                    e.dest   = IF_predDest_p_i[32*k +: 32];
                    e.take   = IF_predTake_p_i[k];
                    e.ckpt   = IF_predInfo_p_i[CKPT_W*k +: CKPT_W];
                    e.exc    = IF_hasException_i;
                    e.refill = IF_isRefill_i;
                    e.code   = IF_ExcCode_i;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic drive(input bit v, input int n, input logic [31:0] base, input int rn,
                         input bit fl, input bit ex, input bit rf, input logic [4:0] code);
        IF_valid_i        = v;
        IF_instNum_i      = 3'(n);
        IF_inst_p_i       = {$urandom, $urandom, $urandom, $urandom};
        IF_predDest_p_i   = {$urandom, $urandom, $urandom, $urandom};
        IF_predTake_p_i   = 4'($urandom);
        IF_predInfo_p_i   = 32'($urandom);
        IF_instBasePC_i   = base;
        IF_hasException_i = ex;
        IF_isRefill_i     = rf;
        IF_ExcCode_i      = code;
        ID_readNum_i      = 2'(rn);
        flush_i           = fl;
        last_inst         = IF_inst_p_i;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int rn);
        drive(1'b0, 0, 32'h0, rn, 1'b0, 1'b0, 1'b0, 5'h00);
    endtask

    task automatic wr(input int n, input logic [31:0] base);
        drive(1'b1, n, base, 0, 1'b0, 1'b0, 1'b0, 5'h00);
    endtask

    // Monitor: compare the visible head entries against the model every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("count", 64'(IQ_count_o), 64'(exp_q.size()));
            chk("allowin", 64'(IQ_allowin_o), 64'((DEPTH - exp_q.size()) >= 4));
            chk("valid", 64'(IQ_valid_o), {62'd0, exp_q.size() >= 2, exp_q.size() >= 1});
            for (int h = 0; h < 2; h++) begin
                if (exp_q.size() > h) begin
                    chk("head_inst", 64'(IQ_inst_o[32*h +: 32]), 64'(exp_q[h].inst));
                    chk("head_pc", 64'(IQ_PC_o[32*h +: 32]), 64'(exp_q[h].pc));
                    chk("head_dest", 64'(IQ_predDest_o[32*h +: 32]), 64'(exp_q[h].dest));
                    chk("head_take", 64'(IQ_predTake_o[h]), 64'(exp_q[h].take));
                    chk("head_ckpt", 64'(IQ_predInfo_o[CKPT_W*h +: CKPT_W]), 64'(exp_q[h].ckpt));
                    chk("head_exc", 64'(IQ_hasException_o[h]), 64'(exp_q[h].exc));
                    chk("head_refill", 64'(IQ_isRefill_o[h]), 64'(exp_q[h].refill));
                    chk("head_code", 64'(IQ_ExcCode_o[5*h +: 5]), 64'(exp_q[h].code));
                end
            end
        end
    end

    initial begin
        logic [127:0] grp;
        rst = 1'b1;
        idle(0);
        idle(0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_allowin", 64'(IQ_allowin_o), 64'd1);
        chk("rst_valid", 64'(IQ_valid_o), 64'd0);
        chk("rst_count", 64'(IQ_count_o), 64'd0);

        // Write three, then consume two.
        wr(3, 32'hBFC00000);
        grp = last_inst;
        @(negedge clk);
        chk("w3_valid", 64'(IQ_valid_o), 64'd3);
        chk("w3_pc0", 64'(IQ_PC_o[31:0]), 64'h0BFC00000);
        chk("w3_pc1", 64'(IQ_PC_o[63:32]), 64'h0BFC00004);
        chk("w3_count", 64'(IQ_count_o), 64'd3);
        idle(2);
        @(negedge clk);
        chk("r2_inst0", 64'(IQ_inst_o[31:0]), 64'(grp[95:64]));
        chk("r2_pc0", 64'(IQ_PC_o[31:0]), 64'h0BFC00008);
        chk("r2_valid", 64'(IQ_valid_o), 64'd1);
        idle(1);

        // Fill to DEPTH, then a rejected fifth group and allow-in recovery.
        for (int i = 0; i < 4; i++) wr(4, 32'h1000 + 32'(16 * i));
        @(negedge clk);
        chk("full_count", 64'(IQ_count_o), 64'd16);
        chk("full_allowin", 64'(IQ_allowin_o), 64'd0);
        wr(4, 32'h2000);
        @(negedge clk);
        chk("rej_count", 64'(IQ_count_o), 64'd16);
        idle(2);
        @(negedge clk);
        chk("c14_count", 64'(IQ_count_o), 64'd14);
        chk("c14_allowin", 64'(IQ_allowin_o), 64'd0);
        idle(2);
        @(negedge clk);
        chk("c12_count", 64'(IQ_count_o), 64'd12);
        chk("c12_allowin", 64'(IQ_allowin_o), 64'd1);

        // Wrap: flush to origin, advance tail to 14, then write a group over the end.
        drive(1'b0, 0, 32'h0, 0, 1'b1, 1'b0, 1'b0, 5'h00);
        wr(4, 32'h3000); wr(4, 32'h3010); wr(4, 32'h3020); wr(2, 32'h3030);
        repeat (7) idle(2);
        wr(4, 32'h8000FFF8);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wrap_pc0", 64'(IQ_PC_o[31:0]), 64'(32'h8000FFF8 + 32'(4 * i)));
            idle(1);
        end

        // Flush overrides a same-cycle write and read.
        wr(4, 32'h4000); wr(2, 32'h4010);
        @(negedge clk);
        chk("pre_flush_count", 64'(IQ_count_o), 64'd6);
        drive(1'b1, 4, 32'h5000, 2, 1'b1, 1'b0, 1'b0, 5'h00);
        @(negedge clk);
        chk("flush_count", 64'(IQ_count_o), 64'd0);
        chk("flush_valid", 64'(IQ_valid_o), 64'd0);
        chk("flush_allowin", 64'(IQ_allowin_o), 64'd1);

        // Exception fields and over-read.
        drive(1'b1, 1, 32'h6000, 0, 1'b0, 1'b1, 1'b1, 5'h04);
        @(negedge clk);
        chk("exc_flag", 64'(IQ_hasException_o[0]), 64'd1);
        chk("exc_refill", 64'(IQ_isRefill_o[0]), 64'd1);
        chk("exc_code", 64'(IQ_ExcCode_o[4:0]), 64'h04);
        idle(3);
        @(negedge clk);
        chk("overread_count", 64'(IQ_count_o), 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom_range(0, 4), $urandom,
                  $urandom_range(0, 3), 1'($urandom_range(0, 31) == 0),
                  1'($urandom), 1'($urandom), 5'($urandom));
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
